src_ldst_sequencer: RTL and testbench
=====================================

// Module: src_ldst_sequencer
// PURPOSE
// - Control-step sequencer for the Mini SRC datapath; generates T0..T7 strobes for fetch + ld/ldi/st execution in RTL.
// - Adds memory wait-state handshake (mem_ready), a wait timeout, and done/fault status.
// - Drives the Datapath control inputs directly; sits between the instruction source and Datapath.
// PARAMETERS
// - OPC_W    5        opcode width (IR[31:27])
// - OP_LD    5'b00000 opcode for ld   Ra, C(Rb)
// - OP_LDI   5'b00001 opcode for ldi  Ra, C(Rb)
// - OP_ST    5'b00010 opcode for st   C(Rb), Ra
// - WAIT_W   4        width of the wait-state counter
// - MAX_WAIT 15       max mem_ready-low cycles tolerated per access (<= 2**WAIT_W-1)
// PORTS
// - Clock      in  1      system clock, rising edge
// - clear      in  1      synchronous active-high reset
// - start      in  1      begin fetch/execute of the next instruction; sampled in IDLE only
// - ir_opcode  in  OPC_W  opcode from IR; sampled in T3
// - mem_ready  in  1      memory completes current Read/Write this cycle
// - PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin  out 1  datapath strobes
// - Yin, Zin, Zlowout, GRA, GRB, Rin, Rout, BAout, Cout          out 1  datapath strobes
// - busy       out 1      high in any state other than IDLE/FAULT
// - done       out 1      one-cycle pulse on instruction completion
// - fault      out 1      sticky: bad opcode or memory timeout
// - step       out 4      current state code (debug)
// BEHAVIOUR
// - Moore machine: all strobes decoded from registered state only; no input-to-output paths.
// - Reset (clear=1 at edge): state=IDLE, wait counter=0, fault=0; every output 0. Applies mid-instruction.
// - States/strobes:
//   IDLE: none. start=1 -> T0. start ignored in all other states.
//   T0: PCout MARin IncPC Zin -> T1
//   T1: Zlowout PCin Read MDRin; mem_ready=1 -> T2, else hold (wait)
//   T2: MDRout IRin -> T3
//   T3: GRB BAout Yin; opcode LD/LDI/ST -> T4, other -> FAULT
//   T4: Cout Zin (ALU add: Rb + C) -> T5
//   T5: LDI: Zlowout GRA Rin -> DONE;  LD/ST: Zlowout MARin -> T6
//   T6: LD: Read MDRin, wait on mem_ready -> T7;  ST: GRA Rout MDRin -> T7
//   T7: LD: MDRout GRA Rin -> DONE;  ST: Write, wait on mem_ready -> DONE
//   DONE: done=1 -> IDLE
//   FAULT: fault=1, all strobes 0; exits only on clear.
// - Opcode latched in T3; later ir_opcode changes have no effect.
// - Wait states: in a wait state with mem_ready=0, strobes held, counter++. Counter clears on state change.
//   mem_ready=0 while counter==MAX_WAIT -> FAULT. Thus max MAX_WAIT wait cycles per access.
// - Latency, start sampled to done pulse (zero waits): LDI 7 cycles, LD/ST 9 cycles; +1 per wait cycle.
// - mem_ready outside wait states is ignored.
// - step encoding: IDLE=0, T0..T7=1..8, DONE=9, FAULT=15.
// STRUCTURE
// - Shared package src_ctrl_pkg: state codes, opcode constants, control-word bit indices.
//   Reused by the ALU/branch sequencers.
// - Sub-module mem_wait_timer (WAIT_W, MAX_WAIT)
//   - inputs: en, ready, restart
//   - output: timeout
// - Remaining logic: next-state block + strobe decode block.
// TESTING
// - ldi, opcode=00001, mem_ready=1 -> step 1,2,3,4,5,6,9,0. done at cycle 7 after start.
//   In T5: Zlowout=GRA=Rin=1, Read=0.
// - ld, opcode=00000, mem_ready=1 -> T6 Read=MDRin=1; T7 MDRout=GRA=Rin=1; done 9 cycles after start.
// - st, opcode=00010, mem_ready low for 3 cycles in T7 -> Write held 4 cycles; done 12 cycles after start.
// - ld, mem_ready held 0 in T1 -> FAULT after MAX_WAIT=15 wait cycles; fault=1, busy=0, strobes 0.
//   fault persists until clear.
// - opcode=5'b11111 at T3 -> FAULT next cycle; start pulses ignored; clear -> IDLE, fault=0.
// - clear asserted in T6 of ld -> next edge step=0, all strobes 0; fresh start runs normally.

Source files
------------

// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: shared state codes, opcodes and control-word layout for the Mini SRC sequencers
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_DONE  = 4'd9,
    S_FAULT = 4'd15
  } state_t;

  localparam int DEF_OPC_W = 5;
  localparam logic [4:0] DEF_OP_LD  = 5'b00000;
  localparam logic [4:0] DEF_OP_LDI = 5'b00001;
  localparam logic [4:0] DEF_OP_ST  = 5'b00010;
  localparam int DEF_WAIT_W   = 4;
  localparam int DEF_MAX_WAIT = 15;

  localparam int CW_PCOUT   = 0;
  localparam int CW_INCPC   = 1;
  localparam int CW_PCIN    = 2;
  localparam int CW_MARIN   = 3;
  localparam int CW_MDRIN   = 4;
  localparam int CW_MDROUT  = 5;
  localparam int CW_READ    = 6;
  localparam int CW_WRITE   = 7;
  localparam int CW_IRIN    = 8;
  localparam int CW_YIN     = 9;
  localparam int CW_ZIN     = 10;
  localparam int CW_ZLOWOUT = 11;
  localparam int CW_GRA     = 12;
  localparam int CW_GRB     = 13;
  localparam int CW_RIN     = 14;
  localparam int CW_ROUT    = 15;
  localparam int CW_BAOUT   = 16;
  localparam int CW_COUT    = 17;
  localparam int CW_W       = 18;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t cw_bit(input int i);
    return ctrl_word_t'(1) << i;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts mem_ready-low cycles of one access and flags when the budget is exhausted
module mem_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ready,
  input  logic restart,
  output logic timeout
);

  logic [WAIT_W-1:0] r_cnt;

  assign timeout = en & ~ready & (r_cnt == WAIT_W'(MAX_WAIT));

  // Count stalled cycles; any state change starts a fresh budget
  always_ff @(posedge clk) begin
    if (rst || restart) r_cnt <= '0;
    else if (en && !ready) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/src_ldst_sequencer.sv
// src_ldst_sequencer: Moore control-step sequencer for fetch plus ld/ldi/st with memory wait states
module src_ldst_sequencer
  import src_ctrl_pkg::*;
#(
  parameter int               OPC_W    = DEF_OPC_W,
  parameter logic [OPC_W-1:0] OP_LD    = DEF_OP_LD,
  parameter logic [OPC_W-1:0] OP_LDI   = DEF_OP_LDI,
  parameter logic [OPC_W-1:0] OP_ST    = DEF_OP_ST,
  parameter int               WAIT_W   = DEF_WAIT_W,
  parameter int               MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             IncPC,
  output logic             PCin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             Write,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             GRA,
  output logic             GRB,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [3:0]       step
);

  state_t           r_state;
  state_t           w_next;
  logic [OPC_W-1:0] r_op;
  logic             w_is_ldi;
  logic             w_is_st;
  logic             w_op_ok;
  logic             w_wait;
  logic             w_timeout;
  ctrl_word_t       w_cw;

  assign w_is_ldi = (r_op == OP_LDI);
  assign w_is_st  = (r_op == OP_ST);
  assign w_op_ok  = (ir_opcode == OP_LD) | (ir_opcode == OP_LDI) | (ir_opcode == OP_ST);
  assign w_wait   = (r_state == S_T1) | ((r_state == S_T6) & ~w_is_st) | ((r_state == S_T7) & w_is_st);

  mem_wait_timer #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk     (Clock),
    .rst     (clear),
    .en      (w_wait),
    .ready   (mem_ready),
    .restart (w_next != r_state),
    .timeout (w_timeout)
  );

  // State register; the opcode is captured once in T3 so later IR changes cannot steer execution
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T3) r_op <= ir_opcode;
    end
  end

  // Next-state: wait states hold until mem_ready, and fall into FAULT once the wait budget is spent
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_T0 : S_IDLE;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = w_timeout ? S_FAULT : mem_ready ? S_T2 : S_T1;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = w_op_ok ? S_T4 : S_FAULT;
      S_T4:    w_next = S_T5;
      S_T5:    w_next = w_is_ldi ? S_DONE : S_T6;
      S_T6:    w_next = w_is_st ? S_T7 : w_timeout ? S_FAULT : mem_ready ? S_T7 : S_T6;
      S_T7:    w_next = !w_is_st ? S_DONE : w_timeout ? S_FAULT : mem_ready ? S_DONE : S_T7;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_FAULT;
    endcase
  end

  // Strobe decode from registered state and latched opcode only
  always_comb begin
    w_cw = '0;
    case (r_state)
      S_T0:    w_cw = cw_bit(CW_PCOUT) | cw_bit(CW_MARIN) | cw_bit(CW_INCPC) | cw_bit(CW_ZIN);
      S_T1:    w_cw = cw_bit(CW_ZLOWOUT) | cw_bit(CW_PCIN) | cw_bit(CW_READ) | cw_bit(CW_MDRIN);
      S_T2:    w_cw = cw_bit(CW_MDROUT) | cw_bit(CW_IRIN);
      S_T3:    w_cw = cw_bit(CW_GRB) | cw_bit(CW_BAOUT) | cw_bit(CW_YIN);
      S_T4:    w_cw = cw_bit(CW_COUT) | cw_bit(CW_ZIN);
      S_T5:    w_cw = w_is_ldi ? (cw_bit(CW_ZLOWOUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN))
                               : (cw_bit(CW_ZLOWOUT) | cw_bit(CW_MARIN));
      S_T6:    w_cw = w_is_st ? (cw_bit(CW_GRA) | cw_bit(CW_ROUT) | cw_bit(CW_MDRIN))
                              : (cw_bit(CW_READ) | cw_bit(CW_MDRIN));
      S_T7:    w_cw = w_is_st ? cw_bit(CW_WRITE)
                              : (cw_bit(CW_MDROUT) | cw_bit(CW_GRA) | cw_bit(CW_RIN));
      default: w_cw = '0;
    endcase
  end

  assign PCout   = w_cw[CW_PCOUT];
  assign IncPC   = w_cw[CW_INCPC];
  assign PCin    = w_cw[CW_PCIN];
  assign MARin   = w_cw[CW_MARIN];
  assign MDRin   = w_cw[CW_MDRIN];
  assign MDRout  = w_cw[CW_MDROUT];
  assign Read    = w_cw[CW_READ];
  assign Write   = w_cw[CW_WRITE];
  assign IRin    = w_cw[CW_IRIN];
  assign Yin     = w_cw[CW_YIN];
  assign Zin     = w_cw[CW_ZIN];
  assign Zlowout = w_cw[CW_ZLOWOUT];
  assign GRA     = w_cw[CW_GRA];
  assign GRB     = w_cw[CW_GRB];
  assign Rin     = w_cw[CW_RIN];
  assign Rout    = w_cw[CW_ROUT];
  assign BAout   = w_cw[CW_BAOUT];
  assign Cout    = w_cw[CW_COUT];

  assign busy  = (r_state != S_IDLE) & (r_state != S_FAULT);
  assign done  = (r_state == S_DONE);
  assign fault = (r_state == S_FAULT);
  assign step  = r_state;

endmodule

// File: tb/tb_src_ldst_sequencer.sv
// tb_src_ldst_sequencer: randomized and directed checks of the ld/ldi/st sequencer against a trace model
module tb_src_ldst_sequencer;

  logic       Clock = 1'b0;
  logic       clear, start, mem_ready;
  logic [4:0] ir_opcode;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin;
  logic Yin, Zin, Zlowout, GRA, GRB, Rin, Rout, BAout, Cout;
  logic busy, done, fault;
  logic [3:0] step;

  always #5 Clock = ~Clock;

  src_ldst_sequencer dut (
    .Clock(Clock), .clear(clear), .start(start), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .GRA(GRA), .GRB(GRB), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .busy(busy), .done(done), .fault(fault), .step(step)
  );

  wire [17:0] obs = {PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, Write, IRin,
                     Yin, Zin, Zlowout, GRA, GRB, Rin, Rout, BAout, Cout};

  localparam logic [17:0] X_PCO = 18'h20000, X_INC = 18'h10000, X_PCI = 18'h08000, X_MAI = 18'h04000;
  localparam logic [17:0] X_MDI = 18'h02000, X_MDO = 18'h01000, X_RD  = 18'h00800, X_WR  = 18'h00400;
  localparam logic [17:0] X_IRI = 18'h00200, X_YIN = 18'h00100, X_ZIN = 18'h00080, X_ZLO = 18'h00040;
  localparam logic [17:0] X_GRA = 18'h00020, X_GRB = 18'h00010, X_RIN = 18'h00008, X_ROU = 18'h00004;
  localparam logic [17:0] X_BAO = 18'h00002, X_COU = 18'h00001;

  typedef struct {
    logic [3:0]  stp;
    logic [17:0] sb;
    logic        st;
    logic        rdy;
    logic [4:0]  opc;
  } ent_t;

  ent_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic push(input logic [3:0] s, input logic [17:0] sb, input logic rdy, input logic [4:0] opc);
    ent_t e;
    e.stp = s; e.sb = sb; e.st = 1'($urandom); e.rdy = rdy; e.opc = opc;
    q.push_back(e);
  endtask

  task automatic mem_phase(input logic [3:0] s, input logic [17:0] sb, input int waits,
                           input logic [4:0] opc, output bit to);
    for (int i = 0; i < waits && i < 16; i++) push(s, sb, 1'b0, opc);
    to = (waits > 15);
    if (!to) push(s, sb, 1'b1, opc);
  endtask

  // kind: 0 ld, 1 ldi, 2 st, 3 illegal opcode; waits of 16 exhaust the 15-cycle budget
  task automatic build(input int kind, input logic [4:0] opc, input int w1, input int w2);
    bit to;
    q.delete();
    push(4'd0, 18'd0, 1'($urandom), opc);
    q[0].st = 1'b1;
    push(4'd1, X_PCO | X_MAI | X_INC | X_ZIN, 1'($urandom), opc);
    mem_phase(4'd2, X_ZLO | X_PCI | X_RD | X_MDI, w1, opc, to);
    if (!to) begin
      push(4'd3, X_MDO | X_IRI, 1'($urandom), opc);
      push(4'd4, X_GRB | X_BAO | X_YIN, 1'($urandom), opc);
      if (kind == 3) to = 1;
      else begin
        push(4'd5, X_COU | X_ZIN, 1'($urandom), 5'($urandom));
        if (kind == 1) push(4'd6, X_ZLO | X_GRA | X_RIN, 1'($urandom), 5'($urandom));
        else push(4'd6, X_ZLO | X_MAI, 1'($urandom), 5'($urandom));
        if (kind == 0) begin
          mem_phase(4'd7, X_RD | X_MDI, w2, 5'($urandom), to);
          if (!to) push(4'd8, X_MDO | X_GRA | X_RIN, 1'($urandom), 5'($urandom));
        end else if (kind == 2) begin
          push(4'd7, X_GRA | X_ROU | X_MDI, 1'($urandom), 5'($urandom));
          mem_phase(4'd8, X_WR, w2, 5'($urandom), to);
        end
        if (!to) begin
          push(4'd9, 18'd0, 1'($urandom), 5'($urandom));
          push(4'd0, 18'd0, 1'($urandom), 5'($urandom));
          q[$].st = 1'b0;
        end
      end
    end
    if (to) repeat (3) push(4'd15, 18'd0, 1'($urandom), 5'($urandom));
  endtask

  task automatic play(input int n);
    logic [2:0] xs;
    for (int i = 0; i < n && i < q.size(); i++) begin
      start = q[i].st; mem_ready = q[i].rdy; ir_opcode = q[i].opc;
      xs = {q[i].stp == 4'd9, q[i].stp != 4'd0 && q[i].stp != 4'd15, q[i].stp == 4'd15};
      n_chk++;
      if (step !== q[i].stp) begin n_err++; $display("FAIL step[%0d] got %0d exp %0d", i, step, q[i].stp); end
      n_chk++;
      if (obs !== q[i].sb) begin n_err++; $display("FAIL strobes[%0d] step %0d got %h exp %h", i, q[i].stp, obs, q[i].sb); end
      n_chk++;
      if ({done, busy, fault} !== xs) begin n_err++; $display("FAIL status[%0d] done/busy/fault got %b exp %b", i, {done, busy, fault}, xs); end
      @(posedge Clock); #1;
    end
    start = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1; start = 1'b1;
    @(posedge Clock); #1;
    clear = 1'b0; start = 1'b0;
    n_chk++;
    if ({step, obs, done, busy, fault} !== 25'd0) begin
      n_err++; $display("FAIL %s clear got step %0d strobes %h dbf %b exp all 0", tag, step, obs, {done, busy, fault});
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b1; mem_ready = 1'b1; ir_opcode = 5'b00001;
    repeat (2) @(posedge Clock);
    #1;
    clear = 1'b0; start = 1'b0;
    n_chk++;
    if ({step, obs, done, busy, fault} !== 25'd0) begin
      n_err++; $display("FAIL reset got step %0d strobes %h dbf %b exp all 0", step, obs, {done, busy, fault});
    end
  endtask

  task automatic test_ldi;      build(1, 5'b00001, 0, 0);  play(q.size()); endtask
  task automatic test_ld;       build(0, 5'b00000, 0, 0);  play(q.size()); endtask
  task automatic test_st_wait;  build(2, 5'b00010, 0, 3);  play(q.size()); endtask

  task automatic test_max_wait;
    build(0, 5'b00000, 15, 15); play(q.size());
    build(2, 5'b00010, 15, 15); play(q.size());
  endtask

  task automatic test_timeout;
    build(0, 5'b00000, 16, 0); play(q.size());
    do_clear("timeout");
    build(2, 5'b00010, 2, 16); play(q.size());
    do_clear("timeout_st");
  endtask

  task automatic test_bad_opcode;
    build(3, 5'b11111, 0, 0); play(q.size());
    do_clear("bad_opcode");
    build(1, 5'b00001, 1, 0); play(q.size());
  endtask

  task automatic test_clear_mid;
    build(0, 5'b00000, 0, 0);
    play(7);
    n_chk++;
    if (step !== 4'd7 || Read !== 1'b1 || MDRin !== 1'b1) begin
      n_err++; $display("FAIL clear_mid_t6 got step %0d Read %b MDRin %b exp 7 1 1", step, Read, MDRin);
    end
    do_clear("clear_mid");
    build(0, 5'b00000, 1, 2); play(q.size());
  endtask

  task automatic test_latency;
    int         exp_lat[3] = '{7, 9, 12};
    logic [4:0] ops[3]     = '{5'b00001, 5'b00000, 5'b00010};
    int n, wr;
    for (int k = 0; k < 3; k++) begin
      ir_opcode = ops[k]; mem_ready = 1'b1; start = 1'b1;
      @(posedge Clock); #1;
      start = 1'b0; n = 1; wr = 0;
      while (done !== 1'b1 && n < 40) begin
        mem_ready = !(k == 2 && n >= 8 && n < 11);
        wr += int'(Write);
        @(posedge Clock); #1;
        n++;
      end
      n_chk++;
      if (done !== 1'b1 || n != exp_lat[k]) begin
        n_err++; $display("FAIL latency op%0d got %0d cycles done %b exp %0d", k, n, done, exp_lat[k]);
      end
      if (k == 2) begin
        n_chk++;
        if (wr != 4) begin n_err++; $display("FAIL write_hold got %0d exp 4", wr); end
      end
      mem_ready = 1'b1;
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_random;
    int kind, w1, w2;
    logic [4:0] opc;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      opc = (kind == 0) ? 5'b00000 : (kind == 1) ? 5'b00001 : (kind == 2) ? 5'b00010 : 5'($urandom_range(3, 31));
      w1 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : ($urandom_range(0, 1) != 0) ? int'($urandom_range(4, 15)) : 16;
      w2 = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : ($urandom_range(0, 1) != 0) ? int'($urandom_range(4, 15)) : 16;
      build(kind, opc, w1, w2);
      play(q.size());
      if (q[$].stp == 4'd15) do_clear("random");
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_opcode = 5'd0;
    test_reset();
    test_ldi();
    test_ld();
    test_st_wait();
    test_latency();
    test_max_wait();
    test_timeout();
    test_bad_opcode();
    test_clear_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
